fifo_packet_tx: RTL and testbench
=================================

// Module: fifo_packet_tx
// PURPOSE
//  Drains 63-bit words from the latch FIFO and sends them off chip as serial UART-style frames.
//  Issues the FIFO's one-cycle active-low read pulse and captures the FIFO data_out.
//  Adds the parity bit the FIFO does not store (odd parity), so each frame carries a 64-bit packet.
//  Sits between the event FIFO and the chip's serial output pad.
// PARAMETERS
//  WORD_WIDTH  63  width of a FIFO word (payload bits per frame)
//  BIT_PERIOD  4   clk cycles per serial bit; minimum 1
//  CNT_WIDTH   16  width of the frames_sent counter
// PORTS
//  clk          in   1           system clock; all state changes on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  tx_enable    in   1           permits new frames; level-sensitive
//  fifo_empty   in   1           FIFO empty flag
//  fifo_data    in   WORD_WIDTH  FIFO data_out
//  read_n       out  1           FIFO read strobe, active low, one clk wide
//  tx_out       out  1           serial output; idles high
//  tx_busy      out  1           high from READ through end of the stop bit
//  frames_sent  out  CNT_WIDTH   saturating count of completed frames
// BEHAVIOUR
//  Reset values (async, immediate): read_n=1, tx_out=1, tx_busy=0, frames_sent=0, state=IDLE,
//   counters=0. All outputs are registered.
//  Frame, in time order: start(0), payload bits 0..WORD_WIDTH-1 LSB first, parity, stop(1).
//   Each bit lasts exactly BIT_PERIOD cycles; a 63-bit frame is 66*BIT_PERIOD cycles.
//  parity = ~^payload, so the total count of ones in payload plus parity is odd.
//  FSM states: IDLE, READ, LOAD, SEND.
//   IDLE: if tx_enable && !fifo_empty at the posedge -> READ, read_n<=0, tx_busy<=1.
//   READ: exactly one cycle -> LOAD, read_n<=1. The FIFO pointer advances on this edge.
//   LOAD: exactly one cycle; the FIFO latch is now closed and stable.
//    At the next posedge: shift_reg<={parity,fifo_data}, tx_out<=0 (start bit), state -> SEND.
//   SEND: clk_cnt counts 0..BIT_PERIOD-1.
//    On wrap, bit_cnt increments and tx_out takes the next bit.
//    After the stop bit's last cycle: tx_out=1, tx_busy<=0, frames_sent+1 (holds at all-ones), -> IDLE.
//  Latency: sampling edge E0 -> read_n low after E0 -> start bit on tx_out after E0+2.
//  Back-to-back frames: IDLE lasts at least one cycle, so inter-frame idle-high gap >= 1 clk.
//  tx_enable drop mid-frame: the current frame completes unchanged; no new READ is issued.
//  fifo_empty is only sampled in IDLE. A change in READ, LOAD or SEND has no effect.
//  read_n is never low for more than one cycle, and never low outside READ.
//  Reset mid-frame: tx_out returns high immediately, the frame is lost, and no read pulse is issued.
//   The FIFO word already popped is discarded.
//  Counter widths: clk_cnt = $clog2(BIT_PERIOD) bits (min 1); bit_cnt = $clog2(WORD_WIDTH+3) bits.
// TESTING
//  1 Reset: hold reset_n=0 with tx_enable=1, fifo_empty=0.
//    -> read_n=1, tx_out=1, tx_busy=0, frames_sent=0 throughout.
//  2 Single frame, BIT_PERIOD=1, fifo_data=63'h1:
//    -> read_n low 1 cycle; start bit 2 cycles later.
//    -> bits: 0, 1, then 62 zeros, parity 0, stop 1; frames_sent=1.
//  3 Parity check, fifo_data=0 -> parity bit 1; fifo_data=all ones (63 ones) -> parity bit 0.
//  4 BIT_PERIOD=4 with 3 words queued:
//    -> each bit held 4 cycles; 3 frames of 264 cycles, each followed by >=1 idle-high cycle.
//    -> exactly 3 read pulses; frames_sent=3.
//  5 Deassert tx_enable at bit 10 of a frame:
//    -> that frame finishes including stop; no further read_n pulse while fifo_empty=0.
//  6 Assert reset_n=0 mid-payload:
//    -> tx_out=1 in the same cycle.
//    -> after release with enable, the next frame starts cleanly with a new read pulse.

Source files
------------

// File: rtl/fifo_packet_tx.sv
// fifo_packet_tx
//   Drains words from the latch FIFO and sends each one off chip as a serial
//   UART-style frame: start(0), payload LSB first, odd parity, stop(1).
//   Every bit is held for BIT_PERIOD clocks.
// Ports
//   clk          system clock, posedge
//   reset_n      asynchronous active-low reset
//   tx_enable    level-sensitive permission to start new frames
//   fifo_empty   FIFO empty flag, sampled only while idle
//   fifo_data    FIFO data_out, captured at the end of LOAD
//   read_n       FIFO read strobe, active low, one clock wide
//   tx_out       serial output, idles high
//   tx_busy      high from READ through the end of the stop bit
//   frames_sent  saturating count of completed frames
module fifo_packet_tx #(
   parameter int WORD_WIDTH = 63,
   parameter int BIT_PERIOD = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tx_enable,
   input  logic                  fifo_empty,
   input  logic [WORD_WIDTH-1:0] fifo_data,
   output logic                  read_n,
   output logic                  tx_out,
   output logic                  tx_busy,
   output logic [CNT_WIDTH-1:0]  frames_sent
);

   localparam int CLK_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int BIT_W = $clog2(WORD_WIDTH + 3);
   localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(BIT_PERIOD - 1);
   // bit_cnt numbers the frame bit currently on the wire: 0 = start,
   // 1..WORD_WIDTH = payload, WORD_WIDTH+1 = parity, WORD_WIDTH+2 = stop
   localparam logic [BIT_W-1:0] PAR_IDX  = BIT_W'(WORD_WIDTH + 1);
   localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(WORD_WIDTH + 2);

   typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

   state_t                 state_q,   state_d;
   logic [CLK_W-1:0]       clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [WORD_WIDTH:0]    shift_q,   shift_d;
   logic                   read_n_q,  read_n_d;
   logic                   tx_q,      tx_d;
   logic                   busy_q,    busy_d;
   logic [CNT_WIDTH-1:0]   sent_q,    sent_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         read_n_q  <= 1'b1;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         read_n_q  <= read_n_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         sent_q    <= sent_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      read_n_d  = read_n_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      sent_d    = sent_q;
      case (state_q)
         IDLE: begin
            if (tx_enable && !fifo_empty) begin
               state_d  = READ;
               read_n_d = 1'b0;
               busy_d   = 1'b1;
            end
         end
         READ: begin
            state_d  = LOAD;
            read_n_d = 1'b1;
         end
         LOAD: begin
            // FIFO latch is closed by now; parity is odd over payload+parity
            shift_d   = {~^fifo_data, fifo_data};
            tx_d      = 1'b0;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = SEND;
         end
         SEND: begin
            if (clk_cnt_q == CLK_LAST) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == STOP_IDX) begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  if (sent_q != '1) sent_d = sent_q + 1'b1;
                  state_d = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  // leaving parity means the stop bit is next; the shifter is spent
                  tx_d      = (bit_cnt_q == PAR_IDX) ? 1'b1 : shift_q[0];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign read_n      = read_n_q;
   assign tx_out      = tx_q;
   assign tx_busy     = busy_q;
   assign frames_sent = sent_q;

endmodule

// File: tb/tb_fifo_packet_tx.sv
// tb_fifo_packet_tx
//   Two instances (BIT_PERIOD 1 and 4) share clock, reset and tx_enable.
//   Each has a latch-FIFO model that pushes the expected word to a scoreboard
//   when it is read; a monitor per instance pops it and checks every frame
//   cycle against the frame rules.
module tb_fifo_packet_tx;
   localparam int W = 63;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic tx_enable = 1'b1;
   logic fe0 = 1'b1, fe1 = 1'b1;
   logic [W-1:0] fd0 = '0, fd1 = '0;
   logic [1:0] read_n, tx_out, tx_busy;
   logic [15:0] fs0, fs1;

   always #5 clk = ~clk;

   fifo_packet_tx #(.WORD_WIDTH(W), .BIT_PERIOD(1), .CNT_WIDTH(16)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable), .fifo_empty(fe0),
      .fifo_data(fd0), .read_n(read_n[0]), .tx_out(tx_out[0]),
      .tx_busy(tx_busy[0]), .frames_sent(fs0));

   fifo_packet_tx #(.WORD_WIDTH(W), .BIT_PERIOD(4), .CNT_WIDTH(16)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable), .fifo_empty(fe1),
      .fifo_data(fd1), .read_n(read_n[1]), .tx_out(tx_out[1]),
      .tx_busy(tx_busy[1]), .frames_sent(fs1));

   logic [W-1:0] fq0[$], fq1[$], ex0[$], ex1[$];
   int pulses0 = 0, pulses1 = 0;
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, id, act, exp, $time);
   endtask

   function automatic logic rd(input int id);   return id != 0 ? read_n[1]  : read_n[0];  endfunction
   function automatic logic txo(input int id);  return id != 0 ? tx_out[1]  : tx_out[0];  endfunction
   function automatic logic bsy(input int id);  return id != 0 ? tx_busy[1] : tx_busy[0]; endfunction
   function automatic logic [15:0] fsent(input int id); return id != 0 ? fs1 : fs0; endfunction
   function automatic int fsize(input int id);  return id != 0 ? fq1.size() : fq0.size(); endfunction
   function automatic int esize(input int id);  return id != 0 ? ex1.size() : ex0.size(); endfunction

   // Frame bit k: start 0, payload LSB first, odd parity, stop 1
   function automatic logic frame_bit(input logic [W-1:0] w, input int k);
      if (k == 0) return 1'b0;
      if (k <= W) return w[k-1];
      if (k == W + 1) return ~^w;
      return 1'b1;
   endfunction

   task automatic push_both(input logic [W-1:0] w);
      fq0.push_back(w);
      fq1.push_back(w);
   endtask

   // Latch FIFO: the word appears during READ, holds through LOAD, then the
   // output is scrambled so a capture at the wrong edge shows up.
   task automatic fifo_model(input int id);
      bit hold = 0;
      logic [63:0] g;
      logic [W-1:0] w;
      forever begin
         @(negedge clk);
         if (hold) hold = 0;
         else if (reset_n && !rd(id)) begin
            if (id != 0) pulses1++; else pulses0++;
            if (fsize(id) > 0) begin
               if (id != 0) begin w = fq1.pop_front(); fd1 = w; ex1.push_back(w); end
               else         begin w = fq0.pop_front(); fd0 = w; ex0.push_back(w); end
               hold = 1;
            end
         end else begin
            g = {$urandom, $urandom};
            if (id != 0) fd1 = g[W-1:0]; else fd0 = g[W-1:0];
         end
         if (id != 0) fe1 = (fq1.size() == 0); else fe0 = (fq0.size() == 0);
      end
   endtask

   task automatic monitor(input int id);
      int bp = (id != 0) ? 4 : 1;
      int cnt = 0;
      bit ab;
      logic [W-1:0] w;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            cnt = 0;
            chk("rst_read_n", id, 64'(rd(id)), 64'd1);
            chk("rst_tx_out", id, 64'(txo(id)), 64'd1);
            chk("rst_tx_busy", id, 64'(bsy(id)), 64'd0);
            chk("rst_frames_sent", id, 64'(fsent(id)), 64'd0);
         end else if (rd(id)) begin
            chk("idle_tx_out", id, 64'(txo(id)), 64'd1);
            chk("idle_tx_busy", id, 64'(bsy(id)), 64'd0);
            chk("idle_frames_sent", id, 64'(fsent(id)), 64'(cnt));
         end else begin
            chk("read_tx_busy", id, 64'(bsy(id)), 64'd1);
            chk("read_tx_out", id, 64'(txo(id)), 64'd1);
            ab = 0;
            w = '0;
            @(negedge clk);
            if (!reset_n) ab = 1;
            else begin
               chk("load_read_n", id, 64'(rd(id)), 64'd1);
               chk("load_tx_out", id, 64'(txo(id)), 64'd1);
               chk("load_tx_busy", id, 64'(bsy(id)), 64'd1);
               chk("exp_word_avail", id, 64'(esize(id) > 0), 64'd1);
               if (esize(id) > 0) w = (id != 0) ? ex1.pop_front() : ex0.pop_front();
               else ab = 1;
            end
            for (int k = 0; k < 66 * bp && !ab; k++) begin
               @(negedge clk);
               if (!reset_n) ab = 1;
               else begin
                  chk($sformatf("tx_bit%0d", k / bp), id, 64'(txo(id)), 64'(frame_bit(w, k / bp)));
                  chk("frame_tx_busy", id, 64'(bsy(id)), 64'd1);
                  chk("frame_read_n", id, 64'(rd(id)), 64'd1);
               end
            end
            if (ab) cnt = 0;
            else begin
               cnt++;
               @(negedge clk);
               if (reset_n) begin
                  chk("gap_read_n", id, 64'(rd(id)), 64'd1);
                  chk("end_tx_out", id, 64'(txo(id)), 64'd1);
                  chk("end_tx_busy", id, 64'(bsy(id)), 64'd0);
                  chk("end_frames_sent", id, 64'(fsent(id)), 64'(cnt));
               end else cnt = 0;
            end
         end
      end
   endtask

   task automatic wait_idle(input string nm);
      int run = 0;
      bit done = 0;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge clk);
         if (fq0.size() == 0 && fq1.size() == 0 && tx_busy == 2'b00 && read_n == 2'b11) run++;
         else run = 0;
         if (run >= 4) done = 1;
      end
      chk({"idle_reached_", nm}, 0, 64'(done), 64'd1);
   endtask

   task automatic wait_read4(input string nm);
      bit found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (read_n[1] == 1'b0) found = 1;
      end
      chk({"read_seen_", nm}, 1, 64'(found), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int p0, p1;
      logic [63:0] r;
      fork
         monitor(0); monitor(1); fifo_model(0); fifo_model(1);
      join_none

      // reset held with enable and a non-empty FIFO
      push_both(63'h1);
      push_both('0);
      push_both('1);
      for (int i = 0; i < 3; i++) begin r = {$urandom, $urandom}; push_both(r[W-1:0]); end
      tx_enable = 1'b1;
      reset_n   = 1'b0;
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b1;
      wait_idle("queued");
      chk("pulses_queued", 0, 64'(pulses0), 64'd6);
      chk("pulses_queued", 1, 64'(pulses1), 64'd6);
      chk("frames_queued", 0, 64'(fs0), 64'd6);
      chk("frames_queued", 1, 64'(fs1), 64'd6);

      // drop tx_enable around bit 10 of a BIT_PERIOD=4 frame
      p0 = pulses0; p1 = pulses1;
      for (int i = 0; i < 3; i++) begin r = {$urandom, $urandom}; push_both(r[W-1:0]); end
      wait_read4("enable_drop");
      repeat (2 + 10 * 4) @(negedge clk);
      tx_enable = 1'b0;
      repeat (800) @(negedge clk);
      chk("pulses_enable_drop", 0, 64'(pulses0 - p0), 64'd1);
      chk("pulses_enable_drop", 1, 64'(pulses1 - p1), 64'd1);
      chk("words_left", 0, 64'(fq0.size()), 64'd2);
      chk("words_left", 1, 64'(fq1.size()), 64'd2);
      chk("frames_enable_drop", 1, 64'(fs1), 64'd7);

      // reset in the middle of the payload
      p0 = pulses0; p1 = pulses1;
      tx_enable = 1'b1;
      wait_read4("reset_mid");
      repeat (20) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_tx_out", 0, 64'(tx_out), 64'd3);
      chk("async_tx_busy", 0, 64'(tx_busy), 64'd0);
      chk("async_read_n", 0, 64'(read_n), 64'd3);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      wait_idle("after_reset");
      chk("pulses_reset", 0, 64'(pulses0 - p0), 64'd2);
      chk("pulses_reset", 1, 64'(pulses1 - p1), 64'd2);
      chk("frames_after_reset", 0, 64'(fs0), 64'd1);
      chk("frames_after_reset", 1, 64'(fs1), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
